// File: rtl/hp0_axi3_write_splitter.sv
// AXI4-to-AXI3 write burst splitter for the HP0 port: chops bursts into <=MAX_BEATS sub-bursts,
// regenerates wlast/wid, and merges the sub-burst B responses into one upstream response.
module hp0_axi3_write_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic [3:0]              s_awcache,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [3:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [3:0]              m_awcache,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic [ID_WIDTH-1:0]     m_wid,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    err_o
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_DATA, S_WAITB, S_RESP} state_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [8:0] MAX_B9      = 9'(MAX_BEATS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            cache_q, cache_d;
  logic [2:0]            prot_q, prot_d;
  logic [8:0]            beats_left_q, beats_left_d;
  logic [4:0]            chunk_beats_q, chunk_beats_d;
  logic [4:0]            beat_cnt_q, beat_cnt_d;
  logic [4:0]            sub_issued_q, sub_issued_d;
  logic [4:0]            sub_done_q, sub_done_d;
  logic [1:0]            resp_acc_q, resp_acc_d;
  logic                  err_q, err_d;

  logic [8:0]            chunk_limit, chunk_len, chunk_len_m1;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic                  chunk_last, burst_last, w_hs;
  logic                  unused_bits;

  // A short WRAP burst must stay whole, so it gets the full AXI3 length limit.
  always_comb begin
    chunk_limit  = (burst_q == BURST_WRAP) ? 9'd16 : MAX_B9;
    chunk_len    = (beats_left_q < chunk_limit) ? beats_left_q : chunk_limit;
    chunk_len_m1 = chunk_len - 9'd1;
    addr_step    = ADDR_WIDTH'(MAX_BEATS) << size_q;
    chunk_last   = (beat_cnt_q == chunk_beats_q - 5'd1);
    burst_last   = chunk_last && (beats_left_q == {4'd0, chunk_beats_q});
    w_hs         = (state_q == S_DATA) && s_wvalid && m_wready;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      id_q          <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      cache_q       <= '0;
      prot_q        <= '0;
      beats_left_q  <= '0;
      chunk_beats_q <= '0;
      beat_cnt_q    <= '0;
      sub_issued_q  <= '0;
      sub_done_q    <= '0;
      resp_acc_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      id_q          <= id_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      cache_q       <= cache_d;
      prot_q        <= prot_d;
      beats_left_q  <= beats_left_d;
      chunk_beats_q <= chunk_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      sub_issued_q  <= sub_issued_d;
      sub_done_q    <= sub_done_d;
      resp_acc_q    <= resp_acc_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    id_d          = id_q;
    size_d        = size_q;
    burst_d       = burst_q;
    cache_d       = cache_q;
    prot_d        = prot_q;
    beats_left_d  = beats_left_q;
    chunk_beats_d = chunk_beats_q;
    beat_cnt_d    = beat_cnt_q;
    sub_issued_d  = sub_issued_q;
    sub_done_d    = sub_done_q;
    resp_acc_d    = resp_acc_q;
    err_d         = err_q;

    // m_bready is tied high, so every m_bvalid cycle is a completed response.
    if (m_bvalid) begin
      sub_done_d = sub_done_q + 5'd1;
      if (m_bresp > resp_acc_q) resp_acc_d = m_bresp;
    end

    case (state_q)
      S_IDLE: begin
        if (s_awvalid) begin
          addr_d  = s_awaddr;
          id_d    = s_awid;
          size_d  = s_awsize;
          burst_d = s_awburst;
          cache_d = s_awcache;
          prot_d  = s_awprot;
          if (s_awburst == 2'd3 || (s_awburst == BURST_WRAP && s_awlen > 8'd15)) begin
            burst_d = BURST_INCR;
            err_d   = 1'b1;
          end
          beats_left_d = {1'b0, s_awlen} + 9'd1;
          resp_acc_d   = 2'b00;
          sub_issued_d = '0;
          sub_done_d   = '0;
          beat_cnt_d   = '0;
          state_d      = S_AW;
        end
      end
      S_AW: begin
        if (m_awready) begin
          chunk_beats_d = chunk_len[4:0];
          sub_issued_d  = sub_issued_q + 5'd1;
          beat_cnt_d    = '0;
          state_d       = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (s_wlast != burst_last) err_d = 1'b1;
          if (chunk_last) begin
            beat_cnt_d   = '0;
            beats_left_d = beats_left_q - {4'd0, chunk_beats_q};
            if (burst_last) begin
              state_d = S_WAITB;
            end else begin
              state_d = S_AW;
              if (burst_q != BURST_FIXED) addr_d = addr_q + addr_step;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      // Compare against the updated count so the merged B leaves one cycle after the last sub-B.
      S_WAITB: if (sub_done_d == sub_issued_q) state_d = S_RESP;
      S_RESP:  if (s_bready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_awready = (state_q == S_IDLE);
    m_awvalid = (state_q == S_AW);
    m_wvalid  = (state_q == S_DATA) && s_wvalid;
    s_wready  = (state_q == S_DATA) && m_wready;
    m_wlast   = (state_q == S_DATA) && chunk_last;
    s_bvalid  = (state_q == S_RESP);
  end

  assign m_awaddr  = addr_q;
  assign m_awid    = id_q;
  assign m_awlen   = chunk_len_m1[3:0];
  assign m_awsize  = size_q;
  assign m_awburst = burst_q;
  assign m_awcache = cache_q;
  assign m_awprot  = prot_q;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wid     = id_q;
  assign m_bready  = 1'b1;
  assign s_bid     = id_q;
  assign s_bresp   = resp_acc_q;
  assign err_o     = err_q;

  assign unused_bits = ^{m_bid, chunk_len_m1[8:4], chunk_len[8:5]};

endmodule
